// File: rtl/midi_pkg.sv
// Shared constants, state encoding and byte-class helpers for the MIDI message parser.
package midi_pkg;

  localparam logic [2:0] MSG_NOTE_OFF = 3'd0;
  localparam logic [2:0] MSG_NOTE_ON  = 3'd1;
  localparam logic [2:0] MSG_POLY_AT  = 3'd2;
  localparam logic [2:0] MSG_CC       = 3'd3;
  localparam logic [2:0] MSG_PROG     = 3'd4;
  localparam logic [2:0] MSG_CHAN_AT  = 3'd5;
  localparam logic [2:0] MSG_PBEND    = 3'd6;

  localparam logic [7:0] RT_CLOCK    = 8'hF8;
  localparam logic [7:0] RT_START    = 8'hFA;
  localparam logic [7:0] RT_CONTINUE = 8'hFB;
  localparam logic [7:0] RT_STOP     = 8'hFC;
  localparam logic [7:0] SYS_SYSEX   = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX,
    ST_SKIP1,
    ST_SKIP2
  } state_e;

  typedef struct packed {
    logic [2:0] typ;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
  } msg_t;

  // Program change and channel aftertouch carry one data byte; every other channel message two.
  function automatic logic [1:0] data_len(input logic [3:0] hi);
    return (hi == 4'hC || hi == 4'hD) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [2:0] msg_class(input logic [3:0] hi);
    logic [2:0] c;
    case (hi)
      4'h8:    c = MSG_NOTE_OFF;
      4'h9:    c = MSG_NOTE_ON;
      4'hA:    c = MSG_POLY_AT;
      4'hB:    c = MSG_CC;
      4'hC:    c = MSG_PROG;
      4'hD:    c = MSG_CHAN_AT;
      default: c = MSG_PBEND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/midi_byte_sync.sv
// Brings the receiver's byte_valid level into CLOCK_25 and turns each rising edge into one strobe
// with the byte captured alongside it.
module midi_byte_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_25,
  input  logic       iRST_N,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       byte_stb,
  output logic [7:0] byte_q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   stb_q;
  logic [7:0]             data_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

  // byte_in is already stable while byte_valid is high, so it is sampled directly on the edge.
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q <= '0;
      last_q <= 1'b0;
      stb_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], byte_valid};
      last_q <= sync_q[SYNC_STAGES-1];
      stb_q  <= rise;
      if (rise) data_q <= byte_in;
    end
  end

  assign byte_stb = stb_q;
  assign byte_q   = data_q;

endmodule

// File: rtl/midi_msg_parser.sv
// Tracks MIDI status/running status, assembles channel-voice messages into a one-entry output slot
// and decodes system real-time bytes into single-cycle pulses.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int MIDI_CH     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_25,
  input  logic       iRST_N,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       omni_en,
  input  logic       msg_ready,
  output logic       msg_valid,
  output logic [2:0] msg_type,
  output logic [3:0] msg_chan,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic       rt_clock,
  output logic       rt_start,
  output logic       rt_continue,
  output logic       rt_stop,
  output logic       ovf
);

  localparam logic [3:0] CH = 4'(MIDI_CH);

  logic       byte_stb;
  logic [7:0] byte_q;

  midi_byte_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLOCK_25  (CLOCK_25),
    .iRST_N    (iRST_N),
    .byte_valid(byte_valid),
    .byte_in   (byte_in),
    .byte_stb  (byte_stb),
    .byte_q    (byte_q)
  );

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic       run_q, run_d;
  logic [6:0] d1_q, d1_d;
  msg_t       msg_q, msg_d;
  logic       msg_valid_q, msg_valid_d;
  logic       ovf_q, ovf_d;
  logic [3:0] rt_q, rt_d;

  logic       take_d1;
  logic       done;
  msg_t       new_msg;

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      status_q    <= 8'h00;
      run_q       <= 1'b0;
      d1_q        <= 7'h00;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      rt_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      run_q       <= run_d;
      d1_q        <= d1_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      ovf_q       <= ovf_d;
      rt_q        <= rt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    run_d       = run_q;
    d1_d        = d1_q;
    msg_d       = msg_q;
    msg_valid_d = msg_valid_q;
    ovf_d       = ovf_q;
    rt_d        = 4'h0;
    take_d1     = 1'b0;
    done        = 1'b0;
    new_msg     = '0;
    new_msg.chan = status_q[3:0];

    if (byte_stb) begin
      if (byte_q >= 8'hF8) begin
        // Real-time bytes interleave anywhere without disturbing message assembly.
        rt_d[0] = (byte_q == RT_CLOCK);
        rt_d[1] = (byte_q == RT_START);
        rt_d[2] = (byte_q == RT_CONTINUE);
        rt_d[3] = (byte_q == RT_STOP);
      end else if (byte_q[7] && byte_q[6:4] != 3'b111) begin
        status_d = byte_q;
        run_d    = 1'b1;
        state_d  = ST_WAIT_D1;
      end else if (byte_q == SYS_SYSEX) begin
        run_d   = 1'b0;
        state_d = ST_SYSEX;
      end else if (byte_q[7]) begin
        run_d = 1'b0;
        case (byte_q)
          8'hF1, 8'hF3: state_d = ST_SKIP1;
          8'hF2:        state_d = ST_SKIP2;
          default:      state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_IDLE:    take_d1 = run_q;
          ST_WAIT_D1: take_d1 = 1'b1;
          ST_WAIT_D2: begin
            done       = 1'b1;
            new_msg.d1 = d1_q;
            new_msg.d2 = byte_q[6:0];
            state_d    = ST_IDLE;
          end
          ST_SKIP2:   state_d = ST_SKIP1;
          ST_SKIP1:   state_d = ST_IDLE;
          default:    state_d = state_q;
        endcase
        if (take_d1) begin
          if (data_len(status_q[7:4]) == 2'd1) begin
            done       = 1'b1;
            new_msg.d1 = byte_q[6:0];
            state_d    = ST_IDLE;
          end else begin
            d1_d    = byte_q[6:0];
            state_d = ST_WAIT_D2;
          end
        end
      end
    end

    new_msg.typ = msg_class(status_q[7:4]);
    if (new_msg.typ == MSG_NOTE_ON && new_msg.d2 == 7'h00) new_msg.typ = MSG_NOTE_OFF;

    // Valid/ready: msg_* hold while msg_valid is high; the slot empties on the edge where
    // msg_valid & msg_ready, and a message completing on that same edge takes its place.
    if (msg_valid_q && msg_ready) msg_valid_d = 1'b0;
    if (done && (omni_en || status_q[3:0] == CH)) begin
      if (!msg_valid_q || msg_ready) begin
        msg_d       = new_msg;
        msg_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign msg_valid   = msg_valid_q;
  assign msg_type    = msg_q.typ;
  assign msg_chan    = msg_q.chan;
  assign msg_d1      = msg_q.d1;
  assign msg_d2      = msg_q.d2;
  assign rt_clock    = rt_q[0];
  assign rt_start    = rt_q[1];
  assign rt_continue = rt_q[2];
  assign rt_stop     = rt_q[3];
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: byte table with expected messages, hand-timed slot sequences and
// a random byte stream checked against a stream-level MIDI model.
module tb_midi_msg_parser;

  localparam int SYNC    = 2;
  localparam int MIDI_CH = 0;

  logic       CLOCK_25 = 1'b0;
  logic       iRST_N = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       omni_en = 1'b1;
  logic       msg_ready = 1'b1;
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [3:0] msg_chan;
  logic [6:0] msg_d1, msg_d2;
  logic       rt_clock, rt_start, rt_continue, rt_stop, ovf;

  midi_msg_parser #(.MIDI_CH(MIDI_CH), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .byte_valid(byte_valid), .byte_in(byte_in),
    .omni_en(omni_en), .msg_ready(msg_ready), .msg_valid(msg_valid), .msg_type(msg_type),
    .msg_chan(msg_chan), .msg_d1(msg_d1), .msg_d2(msg_d2), .rt_clock(rt_clock),
    .rt_start(rt_start), .rt_continue(rt_continue), .rt_stop(rt_stop), .ovf(ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #20 CLOCK_25 = ~CLOCK_25;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [20:0] got_q[$];
  logic [20:0] exp_q[$];
  int rt_cnt[4];
  int exp_rt[4];

  always @(negedge CLOCK_25) begin
    if (msg_valid && msg_ready) got_q.push_back({msg_type, msg_chan, msg_d1, msg_d2});
    if (rt_clock)    rt_cnt[0]++;
    if (rt_start)    rt_cnt[1]++;
    if (rt_continue) rt_cnt[2]++;
    if (rt_stop)     rt_cnt[3]++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    iRST_N = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge CLOCK_25);
    iRST_N = 1'b1;
    @(negedge CLOCK_25);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_25);
    byte_in = b;
    byte_valid = 1'b1;
    repeat (6) @(negedge CLOCK_25);
    byte_valid = 1'b0;
    repeat (5) @(negedge CLOCK_25);
  endtask

  // Raise byte_valid and stop just after edge SYNC+1 (message not yet visible).
  task automatic start_byte_to_edge(input logic [7:0] b);
    @(negedge CLOCK_25);
    byte_in = b;
    byte_valid = 1'b1;
    repeat (SYNC + 1) @(posedge CLOCK_25);
  endtask

  task automatic finish_byte();
    repeat (5) @(negedge CLOCK_25);
    byte_valid = 1'b0;
    repeat (5) @(negedge CLOCK_25);
  endtask

  // ---------------- stream-level reference model ----------------
  int m_status = -1;
  int m_skip = 0;
  logic [6:0] m_buf[$];

  task automatic model_reset();
    m_status = -1;
    m_skip = 0;
    m_buf.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic omni);
    int nib, len, typ, ch;
    logic [6:0] a, d;
    if (b >= 8'hF8) begin
      case (b)
        8'hF8: exp_rt[0]++;
        8'hFA: exp_rt[1]++;
        8'hFB: exp_rt[2]++;
        8'hFC: exp_rt[3]++;
        default: ;
      endcase
    end else if (b >= 8'h80) begin
      m_buf.delete();
      m_skip = 0;
      if (b < 8'hF0) m_status = int'(b);
      else begin
        m_status = -1;
        if (b == 8'hF1 || b == 8'hF3) m_skip = 1;
        else if (b == 8'hF2) m_skip = 2;
      end
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (m_status >= 0) begin
      m_buf.push_back(b[6:0]);
      nib = m_status / 16;
      ch  = m_status % 16;
      len = (nib == 12 || nib == 13) ? 1 : 2;
      if (m_buf.size() == len) begin
        a = m_buf[0];
        d = (len == 2) ? m_buf[1] : 7'd0;
        typ = nib - 8;
        if (nib == 9 && d == 7'd0) typ = 0;
        if (omni || ch == MIDI_CH) exp_q.push_back({typ[2:0], ch[3:0], a, d});
        m_buf.delete();
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b;
    logic       has_msg;
    logic [2:0] typ;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [3:0] rt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [7:0] b, input logic m, input logic [2:0] t,
                             input logic [3:0] c, input logic [6:0] a, input logic [6:0] d,
                             input logic [3:0] rt);
    vec_t r;
    r.b = b; r.has_msg = m; r.typ = t; r.ch = c; r.d1 = a; r.d2 = d; r.rt = rt;
    return r;
  endfunction

  function automatic vec_t nb(input logic [7:0] b);
    return v(b, 1'b0, 3'd0, 4'd0, 7'd0, 7'd0, 4'd0);
  endfunction

  initial begin
    int g0, r0[4];
    logic [7:0] b;
    logic om;
    logic [20:0] g, e;

    tbl.push_back(nb(8'h90)); tbl.push_back(nb(8'h3C));
    tbl.push_back(v(8'h64, 1, 3'd1, 4'd0, 7'd60, 7'd100, 4'h0));
    tbl.push_back(nb(8'h3C));
    tbl.push_back(v(8'h00, 1, 3'd0, 4'd0, 7'd60, 7'd0, 4'h0));
    tbl.push_back(nb(8'hB2)); tbl.push_back(nb(8'h07));
    tbl.push_back(v(8'hF8, 0, 3'd0, 4'd0, 7'd0, 7'd0, 4'h1));
    tbl.push_back(v(8'h7F, 1, 3'd3, 4'd2, 7'd7, 7'd127, 4'h0));
    tbl.push_back(nb(8'hC5));
    tbl.push_back(v(8'h07, 1, 3'd4, 4'd5, 7'd7, 7'd0, 4'h0));
    tbl.push_back(nb(8'hE0)); tbl.push_back(nb(8'h00));
    tbl.push_back(v(8'h40, 1, 3'd6, 4'd0, 7'd0, 7'd64, 4'h0));
    tbl.push_back(nb(8'hF0)); tbl.push_back(nb(8'h7E)); tbl.push_back(nb(8'h09));
    tbl.push_back(nb(8'hF7)); tbl.push_back(nb(8'h3C)); tbl.push_back(nb(8'h64));
    tbl.push_back(nb(8'h80)); tbl.push_back(nb(8'h3C));
    tbl.push_back(v(8'h40, 1, 3'd0, 4'd0, 7'd60, 7'd64, 4'h0));
    tbl.push_back(nb(8'h90));
    tbl.push_back(v(8'hFA, 0, 3'd0, 4'd0, 7'd0, 7'd0, 4'h2));
    tbl.push_back(nb(8'h3C));
    tbl.push_back(v(8'hFB, 0, 3'd0, 4'd0, 7'd0, 7'd0, 4'h4));
    tbl.push_back(v(8'h64, 1, 3'd1, 4'd0, 7'd60, 7'd100, 4'h0));
    tbl.push_back(v(8'hFC, 0, 3'd0, 4'd0, 7'd0, 7'd0, 4'h8));
    tbl.push_back(nb(8'hFE)); tbl.push_back(nb(8'hF9));
    tbl.push_back(nb(8'hF2)); tbl.push_back(nb(8'h01)); tbl.push_back(nb(8'h02));
    tbl.push_back(nb(8'h3C)); tbl.push_back(nb(8'h64));
    tbl.push_back(nb(8'hD3));
    tbl.push_back(v(8'h10, 1, 3'd5, 4'd3, 7'd16, 7'd0, 4'h0));
    tbl.push_back(v(8'h20, 1, 3'd5, 4'd3, 7'd32, 7'd0, 4'h0));
    tbl.push_back(nb(8'hA1)); tbl.push_back(nb(8'h20));
    tbl.push_back(v(8'h30, 1, 3'd2, 4'd1, 7'd32, 7'd48, 4'h0));
    tbl.push_back(nb(8'hF1)); tbl.push_back(nb(8'h05)); tbl.push_back(nb(8'h90));
    tbl.push_back(nb(8'h55)); tbl.push_back(v(8'h66, 1, 3'd1, 4'd0, 7'h55, 7'h66, 4'h0));

    // ---- reset state ----
    do_reset();
    check("reset_msg_valid", 32'(msg_valid), 32'd0);
    check("reset_msg_fields", 32'({msg_type, msg_chan, msg_d1, msg_d2}), 32'd0);
    check("reset_rt_ovf", 32'({rt_clock, rt_start, rt_continue, rt_stop, ovf}), 32'd0);

    // ---- table vectors ----
    omni_en = 1'b1;
    msg_ready = 1'b1;
    got_q.delete();
    foreach (tbl[i]) begin
      g0 = got_q.size();
      for (int k = 0; k < 4; k++) r0[k] = rt_cnt[k];
      send_byte(tbl[i].b);
      check($sformatf("tbl%0d_msg_count", i), 32'(got_q.size() - g0), 32'(tbl[i].has_msg));
      if (tbl[i].has_msg && got_q.size() > g0)
        check($sformatf("tbl%0d_msg", i), 32'(got_q[$]),
              32'({tbl[i].typ, tbl[i].ch, tbl[i].d1, tbl[i].d2}));
      check($sformatf("tbl%0d_rt", i),
            {8'(rt_cnt[3] - r0[3]), 8'(rt_cnt[2] - r0[2]), 8'(rt_cnt[1] - r0[1]), 8'(rt_cnt[0] - r0[0])},
            {7'd0, tbl[i].rt[3], 7'd0, tbl[i].rt[2], 7'd0, tbl[i].rt[1], 7'd0, tbl[i].rt[0]});
    end

    // ---- latency: msg_valid rises SYNC+2 edges after byte_valid is first sampled ----
    do_reset();
    send_byte(8'h90);
    send_byte(8'h3C);
    start_byte_to_edge(8'h64);
    #1 check("latency_not_early", 32'(msg_valid), 32'd0);
    @(posedge CLOCK_25);
    #1 check("latency_valid", 32'(msg_valid), 32'd1);
    check("latency_msg", 32'({msg_type, msg_chan, msg_d1, msg_d2}), 32'({3'd1, 4'd0, 7'd60, 7'd100}));
    finish_byte();
    check("latency_one_beat", 32'(msg_valid), 32'd0);

    // ---- reset mid-message drops partial data and running status ----
    send_byte(8'h91);
    send_byte(8'h3C);
    do_reset();
    g0 = got_q.size();
    send_byte(8'h64);
    send_byte(8'h3C);
    send_byte(8'h64);
    check("reset_mid_msg_none", 32'(got_q.size() - g0), 32'd0);

    // ---- channel filter ----
    do_reset();
    omni_en = 1'b0;
    g0 = got_q.size();
    send_byte(8'h93); send_byte(8'h30); send_byte(8'h50);
    check("filter_drop_count", 32'(got_q.size() - g0), 32'd0);
    check("filter_drop_no_ovf", 32'(ovf), 32'd0);
    send_byte(8'h90); send_byte(8'h30); send_byte(8'h50);
    check("filter_pass_count", 32'(got_q.size() - g0), 32'd1);

    // ---- held slot, same-cycle reload, overflow ----
    do_reset();
    omni_en = 1'b1;
    msg_ready = 1'b0;
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h7F);
    check("hold_valid", 32'(msg_valid), 32'd1);
    check("hold_msg", 32'({msg_type, msg_chan, msg_d1, msg_d2}), 32'({3'd1, 4'd1, 7'h40, 7'h7F}));
    send_byte(8'h91); send_byte(8'h42);
    check("hold_stable", 32'({msg_type, msg_chan, msg_d1, msg_d2}), 32'({3'd1, 4'd1, 7'h40, 7'h7F}));
    start_byte_to_edge(8'h7F);
    @(negedge CLOCK_25);
    msg_ready = 1'b1;
    @(posedge CLOCK_25);
    #1 msg_ready = 1'b0;
    check("reload_valid", 32'(msg_valid), 32'd1);
    check("reload_msg", 32'({msg_type, msg_chan, msg_d1, msg_d2}), 32'({3'd1, 4'd1, 7'h42, 7'h7F}));
    check("reload_no_ovf", 32'(ovf), 32'd0);
    finish_byte();
    send_byte(8'h91); send_byte(8'h41); send_byte(8'h7F);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_slot_kept", 32'({msg_valid, msg_type, msg_chan, msg_d1, msg_d2}),
          32'({1'b1, 3'd1, 4'd1, 7'h42, 7'h7F}));
    omni_en = 1'b0;
    send_byte(8'h93); send_byte(8'h30); send_byte(8'h50);
    check("ovf_filter_slot", 32'({msg_type, msg_chan, msg_d1, msg_d2}), 32'({3'd1, 4'd1, 7'h42, 7'h7F}));
    check("ovf_sticky", 32'(ovf), 32'd1);
    g0 = got_q.size();
    @(negedge CLOCK_25);
    msg_ready = 1'b1;
    repeat (3) @(negedge CLOCK_25);
    check("drain_count", 32'(got_q.size() - g0), 32'd1);
    check("drain_empty", 32'({msg_valid, ovf}), 32'({1'b0, 1'b1}));

    // ---- random stream vs reference model ----
    do_reset();
    model_reset();
    got_q.delete();
    exp_q.delete();
    msg_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rt[k] = 0;
      r0[k] = rt_cnt[k];
    end
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) b = 8'h00;
      else if (r < 50) b = 8'($urandom_range(0, 127));
      else if (r < 75) b = {4'($urandom_range(8, 14)), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15))};
      else if (r < 87) b = 8'($urandom_range(8'hF8, 8'hFF));
      else b = 8'($urandom_range(8'hF0, 8'hF7));
      om = 1'($urandom_range(0, 1));
      omni_en = om;
      model_byte(b, om);
      send_byte(b);
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_q.size() == 0) check($sformatf("rand%0d_unexpected_msg", i), 32'(g), 32'h1FFFFF);
        else begin
          e = exp_q.pop_front();
          check($sformatf("rand%0d_msg", i), 32'(g), 32'(e));
        end
      end
    end
    check("rand_missing_msgs", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("rand_rt%0d_count", k), 32'(rt_cnt[k] - r0[k]), 32'(exp_rt[k]));
    check("rand_no_ovf", 32'(ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
